me_pixel_feeder: RTL and testbench

- Parametrised fetch engine between the shared pixel memory and the ME core.
- Serves the core's level requests `need_cur` / `need_ref` through one shared read port with fixed read latency, and returns each beat as `cur_in` / `ref_in` with a one-cycle valid strobe.
- Keeps per-channel address counters that wrap at configurable frame depths, so consecutive frames stream without software intervention.
- Arbitration between the two channels is either fixed-priority (current first) or round-robin.

---
 rtl/me_pixel_feeder_if.sv | 14 +
 rtl/me_pixel_feeder.sv | 187 ++++++++++++++++++
 tb/tb_me_pixel_feeder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/me_pixel_feeder_if.sv
// Shared pixel-memory read port: the feeder drives the request side (master),
// the memory returns data RD_LAT cycles later (slave).
interface me_pixel_feeder_if #(
  parameter int MEM_W  = 64,
  parameter int ADDR_W = 26
);
  logic              mem_rd_en;
  logic              mem_rd_sel;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [MEM_W-1:0]  mem_rd_data;

  modport master (output mem_rd_en, mem_rd_sel, mem_rd_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, mem_rd_sel, mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/me_pixel_feeder.sv
// Fetch engine feeding current/reference beats from a shared fixed-latency read port to the ME core.
// Optional macro ME_FEED_STATS_EN enables the saturating per-channel strobe counters cur_beats/ref_beats.
module me_pixel_feeder #(
  parameter int PIX_W      = 8,
  parameter int CUR_LANES  = 4,
  parameter int REF_LANES  = 8,
  parameter int CUR_ADDR_W = 24,
  parameter int REF_ADDR_W = 26,
  parameter int CUR_DEPTH  = 8294400,
  parameter int REF_DEPTH  = 23945760,
  parameter int RD_LAT     = 2,
  parameter int ARB_MODE   = 0,
  localparam int MEM_W     = REF_LANES * PIX_W,
  localparam int CUR_W     = CUR_LANES * PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 need_cur,
  input  logic                 need_ref,
  output logic [CUR_W-1:0]     cur_in,
  output logic                 cur_valid,
  output logic [MEM_W-1:0]     ref_in,
  output logic                 ref_valid,
  me_pixel_feeder_if.master    mem,
  output logic                 cur_frame_done,
  output logic                 ref_frame_done,
  output logic [31:0]          cur_beats,
  output logic [31:0]          ref_beats
);

  localparam logic [CUR_ADDR_W-1:0] CUR_LAST = CUR_ADDR_W'(CUR_DEPTH - 1);
  localparam logic [REF_ADDR_W-1:0] REF_LAST = REF_ADDR_W'(REF_DEPTH - 1);

  logic                  busy_cur_r;
  logic                  busy_ref_r;
  logic                  rr_ptr_r;
  logic [CUR_ADDR_W-1:0] cur_addr_r;
  logic [REF_ADDR_W-1:0] ref_addr_r;
  logic [RD_LAT-1:0]     tag_vld_r;
  logic [RD_LAT-1:0]     tag_sel_r;

  logic elig_cur_s;
  logic elig_ref_s;
  logic gnt_cur_s;
  logic gnt_ref_s;
  logic cur_wrap_s;
  logic ref_wrap_s;
  logic ret_cur_s;
  logic ret_ref_s;

  // Arbitration and read-port drive; nothing issues during reset or in a restart cycle.
  always_comb begin
    elig_cur_s = need_cur & ~busy_cur_r & ~restart & rst;
    elig_ref_s = need_ref & ~busy_ref_r & ~restart & rst;
    gnt_cur_s  = 1'b0;
    gnt_ref_s  = 1'b0;
    if ((ARB_MODE == 1) && elig_cur_s && elig_ref_s) begin
      gnt_cur_s = ~rr_ptr_r;
      gnt_ref_s = rr_ptr_r;
    end else if (elig_cur_s) begin
      gnt_cur_s = 1'b1;
    end else if (elig_ref_s) begin
      gnt_ref_s = 1'b1;
    end else begin
      gnt_cur_s = 1'b0;
      gnt_ref_s = 1'b0;
    end

    cur_wrap_s = (cur_addr_r == CUR_LAST);
    ref_wrap_s = (ref_addr_r == REF_LAST);

    mem.mem_rd_en  = gnt_cur_s | gnt_ref_s;
    mem.mem_rd_sel = gnt_ref_s;
    if (gnt_ref_s) begin
      mem.mem_rd_addr = ref_addr_r;
    end else if (gnt_cur_s) begin
      mem.mem_rd_addr = REF_ADDR_W'(cur_addr_r);
    end else begin
      mem.mem_rd_addr = {REF_ADDR_W{1'b0}};
    end

    cur_frame_done = gnt_cur_s & cur_wrap_s;
    ref_frame_done = gnt_ref_s & ref_wrap_s;

    // A return landing in a restart cycle belongs to the abandoned stream.
    ret_cur_s = tag_vld_r[RD_LAT-1] & ~tag_sel_r[RD_LAT-1] & ~restart;
    ret_ref_s = tag_vld_r[RD_LAT-1] &  tag_sel_r[RD_LAT-1] & ~restart;
  end

  // Counters, busy flags, tag pipeline and registered return path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cur_r <= 1'b0;
      busy_ref_r <= 1'b0;
      rr_ptr_r   <= 1'b0;
      cur_addr_r <= {CUR_ADDR_W{1'b0}};
      ref_addr_r <= {REF_ADDR_W{1'b0}};
      tag_vld_r  <= {RD_LAT{1'b0}};
      tag_sel_r  <= {RD_LAT{1'b0}};
      cur_in     <= {CUR_W{1'b0}};
      ref_in     <= {MEM_W{1'b0}};
      cur_valid  <= 1'b0;
      ref_valid  <= 1'b0;
    end else if (restart) begin
      busy_cur_r <= 1'b0;
      busy_ref_r <= 1'b0;
      cur_addr_r <= {CUR_ADDR_W{1'b0}};
      ref_addr_r <= {REF_ADDR_W{1'b0}};
      tag_vld_r  <= {RD_LAT{1'b0}};
      tag_sel_r  <= {RD_LAT{1'b0}};
      cur_valid  <= 1'b0;
      ref_valid  <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_sel_r[i] <= tag_sel_r[i-1];
      end
      tag_vld_r[0] <= gnt_cur_s | gnt_ref_s;
      tag_sel_r[0] <= gnt_ref_s;

      cur_valid <= ret_cur_s;
      ref_valid <= ret_ref_s;
      if (ret_cur_s) begin
        cur_in <= mem.mem_rd_data[CUR_W-1:0];
      end else begin
        cur_in <= cur_in;
      end
      if (ret_ref_s) begin
        ref_in <= mem.mem_rd_data;
      end else begin
        ref_in <= ref_in;
      end

      // Busy clears at the end of the strobe cycle, so re-issue lands one cycle after it.
      busy_cur_r <= gnt_cur_s | (busy_cur_r & ~cur_valid);
      busy_ref_r <= gnt_ref_s | (busy_ref_r & ~ref_valid);

      if (gnt_cur_s) begin
        cur_addr_r <= cur_wrap_s ? {CUR_ADDR_W{1'b0}} : cur_addr_r + CUR_ADDR_W'(1);
      end else begin
        cur_addr_r <= cur_addr_r;
      end
      if (gnt_ref_s) begin
        ref_addr_r <= ref_wrap_s ? {REF_ADDR_W{1'b0}} : ref_addr_r + REF_ADDR_W'(1);
      end else begin
        ref_addr_r <= ref_addr_r;
      end

      if (gnt_cur_s) begin
        rr_ptr_r <= 1'b1;
      end else if (gnt_ref_s) begin
        rr_ptr_r <= 1'b0;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

`ifdef ME_FEED_STATS_EN
  // Saturating strobe counters, cleared by reset and restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_beats <= 32'd0;
      ref_beats <= 32'd0;
    end else if (restart) begin
      cur_beats <= 32'd0;
      ref_beats <= 32'd0;
    end else begin
      if (ret_cur_s && (cur_beats != 32'hFFFF_FFFF)) begin
        cur_beats <= cur_beats + 32'd1;
      end else begin
        cur_beats <= cur_beats;
      end
      if (ret_ref_s && (ref_beats != 32'hFFFF_FFFF)) begin
        ref_beats <= ref_beats + 32'd1;
      end else begin
        ref_beats <= ref_beats;
      end
    end
  end
`else
  assign cur_beats = 32'd0;
  assign ref_beats = 32'd0;
`endif

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Bench for me_pixel_feeder: two instances (fixed priority and round-robin) share stimulus;
// each has its own memory delay line, reference model and strobe scoreboard.
module tb_me_pixel_feeder;

  localparam int PIX_W     = 8;
  localparam int CUR_LANES = 4;
  localparam int REF_LANES = 8;
  localparam int MEM_W     = REF_LANES * PIX_W;
  localparam int CUR_W     = CUR_LANES * PIX_W;
  localparam int CUR_DEPTH = 4;
  localparam int REF_DEPTH = 6;
  localparam int RD_LAT    = 2;

  typedef struct {
    int               t;
    logic [MEM_W-1:0] d;
  } exp_t;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic restart  = 1'b0;
  logic need_cur = 1'b0;
  logic need_ref = 1'b0;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;

  logic [MEM_W-1:0] cur_mem [CUR_DEPTH];
  logic [MEM_W-1:0] ref_mem [REF_DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (arb %0d, cycle %0d): got %h, expected %h", name, inst, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    me_pixel_feeder_if #(.MEM_W(MEM_W), .ADDR_W(26)) bus ();
    logic [CUR_W-1:0] cur_in;
    logic             cur_valid;
    logic [MEM_W-1:0] ref_in;
    logic             ref_valid;
    logic             cfd;
    logic             rfd;
    logic [31:0]      cb;
    logic [31:0]      rb;
    logic [MEM_W-1:0] pipe [RD_LAT];

    me_pixel_feeder #(
      .PIX_W(PIX_W), .CUR_LANES(CUR_LANES), .REF_LANES(REF_LANES),
      .CUR_ADDR_W(24), .REF_ADDR_W(26), .CUR_DEPTH(CUR_DEPTH), .REF_DEPTH(REF_DEPTH),
      .RD_LAT(RD_LAT), .ARB_MODE(g)
    ) dut (
      .clk(clk), .rst(rst), .restart(restart), .need_cur(need_cur), .need_ref(need_ref),
      .cur_in(cur_in), .cur_valid(cur_valid), .ref_in(ref_in), .ref_valid(ref_valid),
      .mem(bus), .cur_frame_done(cfd), .ref_frame_done(rfd),
      .cur_beats(cb), .ref_beats(rb)
    );

    // Memory: requested word appears exactly RD_LAT cycles after the read, junk otherwise.
    always @(posedge clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      if (bus.mem_rd_en)
        pipe[0] <= bus.mem_rd_sel ? ref_mem[int'(bus.mem_rd_addr) % REF_DEPTH]
                                  : cur_mem[int'(bus.mem_rd_addr) % CUR_DEPTH];
      else
        pipe[0] <= {$urandom, $urandom};
    end
    assign bus.mem_rd_data = pipe[RD_LAT-1];

    exp_t cq[$];
    exp_t rq[$];
    int   caddr = 0, raddr = 0, cfree = 0, rfree = 0, ccount = 0, rcount = 0;
    bit   ptr = 1'b0;

    always @(negedge clk) begin
      bit   ec, er, gc, gr;
      exp_t e;
      if (!rst) begin
        cq.delete(); rq.delete();
        caddr = 0; raddr = 0; cfree = 0; rfree = 0; ccount = 0; rcount = 0; ptr = 1'b0;
        chk("rst_rd_en", g, 64'(bus.mem_rd_en), 64'd0);
        chk("rst_rd_addr", g, 64'(bus.mem_rd_addr), 64'd0);
        chk("rst_cur_valid", g, 64'(cur_valid), 64'd0);
        chk("rst_ref_valid", g, 64'(ref_valid), 64'd0);
        chk("rst_cur_in", g, 64'(cur_in), 64'd0);
        chk("rst_ref_in", g, 64'(ref_in), 64'd0);
        chk("rst_frame_done", g, 64'({cfd, rfd}), 64'd0);
        chk("rst_beats", g, {cb, rb}, 64'd0);
      end else begin
        // Scoreboard: every strobe must match the oldest expected return of its channel.
        if (cur_valid) begin
          if (cq.size() == 0) chk("cur_valid_unexpected", g, 64'(cur_valid), 64'd0);
          else begin
            e = cq.pop_front();
            chk("cur_strobe_cycle", g, 64'(cyc), 64'(e.t));
            chk("cur_in", g, 64'(cur_in), 64'(e.d[CUR_W-1:0]));
            ccount++;
          end
        end else if (cq.size() > 0 && cq[0].t <= cyc) begin
          chk("cur_valid_missing", g, 64'(cur_valid), 64'd1);
          void'(cq.pop_front());
        end
        if (ref_valid) begin
          if (rq.size() == 0) chk("ref_valid_unexpected", g, 64'(ref_valid), 64'd0);
          else begin
            e = rq.pop_front();
            chk("ref_strobe_cycle", g, 64'(cyc), 64'(e.t));
            chk("ref_in", g, ref_in, e.d);
            rcount++;
          end
        end else if (rq.size() > 0 && rq[0].t <= cyc) begin
          chk("ref_valid_missing", g, 64'(ref_valid), 64'd1);
          void'(rq.pop_front());
        end
`ifdef ME_FEED_STATS_EN
        chk("cur_beats", g, 64'(cb), 64'(ccount));
        chk("ref_beats", g, 64'(rb), 64'(rcount));
`else
        chk("beats_off", g, {cb, rb}, 64'd0);
`endif

        // Reference model: a channel may issue once its previous strobe cycle has passed.
        ec = need_cur && (cyc >= cfree) && !restart;
        er = need_ref && (cyc >= rfree) && !restart;
        gc = 1'b0;
        gr = 1'b0;
        if (ec && er) begin
          if (g == 1) begin gc = !ptr; gr = ptr; end
          else gc = 1'b1;
        end else begin
          gc = ec;
          gr = er;
        end
        chk("rd_en", g, 64'(bus.mem_rd_en), 64'(gc || gr));
        if (gc || gr) begin
          chk("rd_sel", g, 64'(bus.mem_rd_sel), 64'(gr));
          chk("rd_addr", g, 64'(bus.mem_rd_addr), 64'(gr ? raddr : caddr));
        end
        chk("cur_frame_done", g, 64'(cfd), 64'(gc && caddr == CUR_DEPTH - 1));
        chk("ref_frame_done", g, 64'(rfd), 64'(gr && raddr == REF_DEPTH - 1));
        if (gc) begin
          e.t = cyc + RD_LAT + 1; e.d = cur_mem[caddr]; cq.push_back(e);
          cfree = cyc + RD_LAT + 2; caddr = (caddr + 1) % CUR_DEPTH; ptr = 1'b1;
        end
        if (gr) begin
          e.t = cyc + RD_LAT + 1; e.d = ref_mem[raddr]; rq.push_back(e);
          rfree = cyc + RD_LAT + 2; raddr = (raddr + 1) % REF_DEPTH; ptr = 1'b0;
        end
        if (restart) begin
          cq.delete(); rq.delete();
          caddr = 0; raddr = 0; cfree = 0; rfree = 0; ccount = 0; rcount = 0;
        end
      end
    end
  end

  task automatic step(input logic r, input logic rs, input logic nc, input logic nr);
    @(posedge clk);
    #1;
    rst = r; restart = rs; need_cur = nc; need_ref = nr;
  endtask

  initial begin
    for (int i = 0; i < CUR_DEPTH; i++) cur_mem[i] = {$urandom, $urandom};
    for (int i = 0; i < REF_DEPTH; i++) ref_mem[i] = {$urandom, $urandom};
    cur_mem[0] = 64'h0807_0605_0403_0201;
    #1 rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Current only: latency, re-issue spacing and wrap 0,1,2,3,0.
    repeat (24) step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    // Both held: priority / alternation behaviour.
    repeat (30) step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    // Reset one cycle after an issue.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
    // Restart one cycle after an issue.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0);
    // Randomised traffic with occasional restart and reset.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 6));
    end
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
